// File: rtl/pedal_misapply_detector_pkg.sv
// Shared types and default thresholds for the pedal misapplication detector.
// Ticks come from the system clock divider.
package misapply_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_WARN    = 2'd2,
    ST_CUT     = 2'd3
  } state_e;

  localparam logic [7:0] PCT_MAX = 8'd100;

  localparam int ACCEL_HIGH_DEF      = 80;
  localparam int SPIKE_DELTA_DEF     = 40;
  localparam int SPEED_LOW_DEF       = 10;
  localparam int SUSPECT_SAMPLES_DEF = 3;
  localparam int WARN_SECONDS_DEF    = 2;
  localparam int RELEASE_PCT_DEF     = 10;

  function automatic logic [7:0] clamp_pct(input logic [7:0] v);
    return (v > PCT_MAX) ? PCT_MAX : v;
  endfunction

endpackage

// File: rtl/pedal_misapply_detector_if.sv
// Pedal/speed inputs and decision outputs of the pedal misapplication detector.
interface pedal_misapply_detector_if;
  // No valid/ready here: tick_10hz and tick_1hz are single-cycle strobes, the
  // remaining inputs are levels sampled on the strobes, outputs are registered.
  logic       tick_10hz;
  logic       tick_1hz;
  logic [7:0] accel_pct;
  logic       brake_on;
  logic [7:0] speed_kmh;
  logic       ack;

  logic [1:0] state;
  logic       warn;
  logic       throttle_cut;
  logic [7:0] accel_limited;
  logic       event_pulse;
  logic [7:0] event_count;

  modport master (
    output tick_10hz, tick_1hz, accel_pct, brake_on, speed_kmh, ack,
    input  state, warn, throttle_cut, accel_limited, event_pulse, event_count
  );

  modport slave (
    input  tick_10hz, tick_1hz, accel_pct, brake_on, speed_kmh, ack,
    output state, warn, throttle_cut, accel_limited, event_pulse, event_count
  );
endinterface

// File: rtl/pedal_misapply_detector_accel_sampler.sv
// Clamps the accelerator, keeps the previous 10 Hz sample and flags high
// presses and upward spikes relative to that sample.
module accel_sampler
  import misapply_pkg::*;
#(
  parameter int ACCEL_HIGH  = ACCEL_HIGH_DEF,
  parameter int SPIKE_DELTA = SPIKE_DELTA_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_10hz_i,
  input  logic [7:0] accel_pct_i,
  output logic [7:0] acc_o,
  output logic       spike_o,
  output logic       high_o
);

  localparam logic [7:0] HIGH_B  = 8'(ACCEL_HIGH);
  localparam logic [7:0] DELTA_B = 8'(SPIKE_DELTA);

  logic [7:0] prev_q;
  logic       primed_q;

  assign acc_o = clamp_pct(accel_pct_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 8'd0;
      primed_q <= 1'b0;
    end else if (tick_10hz_i) begin
      prev_q   <= acc_o;
      primed_q <= 1'b1;
    end
  end

  // The acc >= prev guard keeps the unsigned difference from wrapping.
  assign spike_o = primed_q && (acc_o >= prev_q) && ((acc_o - prev_q) >= DELTA_B);
  assign high_o  = (acc_o >= HIGH_B);

endmodule

// File: rtl/pedal_misapply_detector.sv
// Pedal misapplication FSM: IDLE -> SUSPECT -> WARN -> CUT, with event counting
// and the downstream throttle command.
module pedal_misapply_detector
  import misapply_pkg::*;
#(
  parameter int ACCEL_HIGH      = ACCEL_HIGH_DEF,
  parameter int SPIKE_DELTA     = SPIKE_DELTA_DEF,
  parameter int SPEED_LOW       = SPEED_LOW_DEF,
  parameter int SUSPECT_SAMPLES = SUSPECT_SAMPLES_DEF,
  parameter int WARN_SECONDS    = WARN_SECONDS_DEF,
  parameter int RELEASE_PCT     = RELEASE_PCT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pedal_misapply_detector_if.slave    bus
);

  localparam logic [7:0] SPEED_LOW_B   = 8'(SPEED_LOW);
  localparam logic [7:0] SUS_N_B       = 8'(SUSPECT_SAMPLES);
  localparam logic [7:0] WARN_SEC_B    = 8'(WARN_SECONDS);
  localparam logic [7:0] RELEASE_B     = 8'(RELEASE_PCT);

  logic [7:0] acc;
  logic       spike;
  logic       high;
  logic       trig;
  logic       released;

  state_e     state_q, state_d;
  logic [7:0] sus_cnt_q, sus_cnt_d;
  logic [7:0] sec_cnt_q, sec_cnt_d;
  logic       enter_warn;

  logic       warn_q, warn_d;
  logic       cut_q, cut_d;
  logic [7:0] accel_limited_q, accel_limited_d;
  logic       event_pulse_q, event_pulse_d;
  logic [7:0] event_count_q, event_count_d;

  accel_sampler #(
    .ACCEL_HIGH  (ACCEL_HIGH),
    .SPIKE_DELTA (SPIKE_DELTA)
  ) u_sampler (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_10hz_i (bus.tick_10hz),
    .accel_pct_i (bus.accel_pct),
    .acc_o       (acc),
    .spike_o     (spike),
    .high_o      (high)
  );

  assign trig     = (high && bus.brake_on) || (spike && (bus.speed_kmh < SPEED_LOW_B));
  assign released = (acc <= RELEASE_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sus_cnt_q <= 8'd0;
      sec_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      sus_cnt_q <= sus_cnt_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sus_cnt_d  = sus_cnt_q;
    sec_cnt_d  = sec_cnt_q;
    enter_warn = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.tick_10hz && trig) begin
          sus_cnt_d = 8'd1;
          if (sus_cnt_d >= SUS_N_B) begin
            state_d    = ST_WARN;
            enter_warn = 1'b1;
          end else begin
            state_d = ST_SUSPECT;
          end
        end
      end
      ST_SUSPECT: begin
        if (bus.tick_10hz) begin
          if (!trig) begin
            state_d   = ST_IDLE;
            sus_cnt_d = 8'd0;
          end else begin
            sus_cnt_d = sus_cnt_q + 8'd1;
            if (sus_cnt_d >= SUS_N_B) begin
              state_d    = ST_WARN;
              enter_warn = 1'b1;
            end
          end
        end
      end
      ST_WARN: begin
        // A release sample wins over a coincident 1 Hz tick.
        if (bus.tick_10hz && released) begin
          state_d   = ST_IDLE;
          sus_cnt_d = 8'd0;
        end else if (bus.tick_1hz) begin
          sec_cnt_d = sec_cnt_q + 8'd1;
          if (sec_cnt_d >= WARN_SEC_B) state_d = ST_CUT;
        end
      end
      ST_CUT: begin
        if (bus.tick_10hz && released && bus.ack) begin
          state_d   = ST_IDLE;
          sus_cnt_d = 8'd0;
        end
      end
    endcase
    if (enter_warn) sec_cnt_d = 8'd0;
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    warn_d          = (state_d == ST_WARN) || (state_d == ST_CUT);
    cut_d           = (state_d == ST_CUT);
    accel_limited_d = cut_d ? 8'd0 : acc;
    event_pulse_d   = enter_warn;
    event_count_d   = event_count_q;
    if (enter_warn && (event_count_q != 8'hFF)) event_count_d = event_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warn_q          <= 1'b0;
      cut_q           <= 1'b0;
      accel_limited_q <= 8'd0;
      event_pulse_q   <= 1'b0;
      event_count_q   <= 8'd0;
    end else begin
      warn_q          <= warn_d;
      cut_q           <= cut_d;
      accel_limited_q <= accel_limited_d;
      event_pulse_q   <= event_pulse_d;
      event_count_q   <= event_count_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.warn          = warn_q;
  assign bus.throttle_cut  = cut_q;
  assign bus.accel_limited = accel_limited_q;
  assign bus.event_pulse   = event_pulse_q;
  assign bus.event_count   = event_count_q;

endmodule

// File: tb/tb_pedal_misapply_detector.sv
// Bench for pedal_misapply_detector: directed scenarios followed by randomized
// pedal/tick traffic, all scored against a cycle-level behavioural model.
module tb_pedal_misapply_detector;

  localparam int T_HIGH = 80;
  localparam int T_DELTA = 40;
  localparam int T_SPEED = 10;
  localparam int T_SUS = 3;
  localparam int T_SECS = 2;
  localparam int T_REL = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #4 clk = ~clk;

  pedal_misapply_detector_if bus ();

  pedal_misapply_detector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err = 0;
  int pulse_seen = 0;

  // {state[20:19], warn[18], cut[17], accel_limited[16:9], pulse[8], count[7:0]}
  logic [20:0] exp_q[$];

  // Model: mode 0 idle, 1 suspect, 2 warn, 3 cut.
  int m_mode, m_sus, m_sec, m_prev, m_cnt;
  bit m_primed;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sus = 0; m_sec = 0; m_prev = 0; m_cnt = 0; m_primed = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit t10, input bit t1);
    int acc;
    bit trig, rel, pulse;
    acc = (int'(bus.accel_pct) > 100) ? 100 : int'(bus.accel_pct);
    rel = (acc <= T_REL);
    trig = (acc >= T_HIGH && bus.brake_on) ||
           (m_primed && acc >= m_prev && (acc - m_prev) >= T_DELTA && int'(bus.speed_kmh) < T_SPEED);
    pulse = 1'b0;
    if (m_mode == 0) begin
      if (t10 && trig) begin m_mode = 1; m_sus = 1; end
    end else if (m_mode == 1) begin
      if (t10) begin
        if (!trig) begin m_mode = 0; m_sus = 0; end
        else m_sus = m_sus + 1;
      end
    end else if (m_mode == 2) begin
      if (t10 && rel) m_mode = 0;
      else if (t1) begin
        m_sec = m_sec + 1;
        if (m_sec >= T_SECS) m_mode = 3;
      end
    end else begin
      if (t10 && rel && bus.ack) m_mode = 0;
    end
    if (m_mode == 1 && m_sus >= T_SUS) begin
      m_mode = 2; m_sec = 0; pulse = 1'b1;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end
    if (t10) begin m_prev = acc; m_primed = 1'b1; end
    exp_q.push_back({2'(m_mode), 1'(m_mode >= 2), 1'(m_mode == 3),
                     8'((m_mode == 3) ? 0 : acc), pulse, 8'(m_cnt)});
  endtask

  task automatic compare_outputs();
    logic [20:0] e;
    e = exp_q.pop_front();
    check_eq("state", 32'(bus.state), 32'(e[20:19]));
    check_eq("warn", 32'(bus.warn), 32'(e[18]));
    check_eq("throttle_cut", 32'(bus.throttle_cut), 32'(e[17]));
    check_eq("accel_limited", 32'(bus.accel_limited), 32'(e[16:9]));
    check_eq("event_pulse", 32'(bus.event_pulse), 32'(e[8]));
    check_eq("event_count", 32'(bus.event_count), 32'(e[7:0]));
    if (bus.event_pulse === 1'b1) pulse_seen++;
  endtask

  task automatic set_in(input int accel, input bit brake, input int speed, input bit ack);
    bus.accel_pct = 8'(accel);
    bus.brake_on  = brake;
    bus.speed_kmh = 8'(speed);
    bus.ack       = ack;
  endtask

  task automatic cycle(input bit t10, input bit t1);
    bus.tick_10hz = t10;
    bus.tick_1hz  = t1;
    @(posedge clk);
    model_step(t10, t1);
    #1;
    compare_outputs();
    bus.tick_10hz = 1'b0;
    bus.tick_1hz  = 1'b0;
  endtask

  task automatic sample();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_state", 32'(bus.state), 0);
    check_eq("rst_warn", 32'(bus.warn), 0);
    check_eq("rst_cut", 32'(bus.throttle_cut), 0);
    check_eq("rst_accel_limited", 32'(bus.accel_limited), 0);
    check_eq("rst_event_pulse", 32'(bus.event_pulse), 0);
    check_eq("rst_event_count", 32'(bus.event_count), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic reach_warn();
    set_in(90, 1'b1, 50, 1'b0);
    repeat (T_SUS) sample();
  endtask

  initial begin
    bus.tick_10hz = 1'b0;
    bus.tick_1hz  = 1'b0;
    set_in(0, 1'b0, 0, 1'b0);
    do_reset();

    // Brake with accelerator.
    pulse_seen = 0;
    set_in(90, 1'b1, 50, 1'b0);
    sample();
    check_eq("brake_suspect_after_1", 32'(bus.state), 1);
    sample();
    sample();
    check_eq("brake_warn_after_3", 32'(bus.state), 2);
    check_eq("brake_single_pulse", 32'(pulse_seen), 1);
    check_eq("brake_event_count", 32'(bus.event_count), 1);

    // Escalation to CUT with two 1 Hz ticks.
    set_in(90, 1'b0, 50, 1'b0);
    cycle(1'b0, 1'b1);
    check_eq("esc_still_warn", 32'(bus.state), 2);
    cycle(1'b0, 1'b1);
    check_eq("esc_cut_state", 32'(bus.state), 3);
    check_eq("esc_throttle_cut", 32'(bus.throttle_cut), 1);
    check_eq("esc_accel_limited_zero", 32'(bus.accel_limited), 0);

    // CUT exit needs release plus ack on a sample.
    set_in(5, 1'b0, 50, 1'b0);
    sample();
    check_eq("cut_hold_no_ack", 32'(bus.state), 3);
    set_in(5, 1'b0, 50, 1'b1);
    sample();
    check_eq("cut_exit_state", 32'(bus.state), 0);
    check_eq("cut_exit_accel_follows", 32'(bus.accel_limited), 5);
    bus.ack = 1'b0;

    // Release sample coinciding with the second 1 Hz tick.
    do_reset();
    reach_warn();
    set_in(90, 1'b0, 50, 1'b0);
    cycle(1'b0, 1'b1);
    set_in(5, 1'b0, 50, 1'b0);
    cycle(1'b1, 1'b1);
    check_eq("simul_release_idle", 32'(bus.state), 0);
    check_eq("simul_no_cut", 32'(bus.throttle_cut), 0);
    cycle(1'b0, 1'b0);

    // Low-speed spike; the held level no longer rises so the next sample clears it.
    do_reset();
    set_in(0, 1'b0, 5, 1'b0);
    sample();
    set_in(60, 1'b0, 5, 1'b0);
    sample();
    check_eq("spike_trig_second_sample", 32'(bus.state), 1);
    sample();
    check_eq("spike_held_back_idle", 32'(bus.state), 0);
    do_reset();
    set_in(0, 1'b0, 30, 1'b0);
    sample();
    set_in(60, 1'b0, 30, 1'b0);
    sample();
    check_eq("spike_fast_stays_idle", 32'(bus.state), 0);

    // Reset mid-WARN; first sample after reset must not spike.
    do_reset();
    reach_warn();
    check_eq("pre_reset_warn", 32'(bus.state), 2);
    #2;
    set_in(90, 1'b0, 0, 1'b0);
    do_reset();
    sample();
    check_eq("post_reset_no_spike", 32'(bus.state), 0);
    set_in(200, 1'b0, 50, 1'b0);
    cycle(1'b0, 1'b0);
    check_eq("clamp_200_to_100", 32'(bus.accel_limited), 100);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      int r, accel;
      r = $urandom_range(0, 9);
      if (r <= 2) accel = $urandom_range(0, 10);
      else if (r <= 6) accel = $urandom_range(80, 100);
      else if (r == 7) accel = $urandom_range(101, 255);
      else accel = $urandom_range(0, 255);
      set_in(accel, $urandom_range(0, 2) != 0,
             ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9) : $urandom_range(10, 255),
             $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
